// File: rtl/access_control_pkg.sv
// Shared types and constants for the access_control password-check stage.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package access_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        GRANTED = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_PW = 16'h1234;
    localparam logic [15:0] MASTER_KEY = 16'hBEEF;

    // Lockout counter width: holds LOCKOUT_CYCLES-1, never narrower than 1 bit.
    function automatic int lockout_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/access_control_if.sv
// Bundles the controller-facing password inputs and the status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; load and logout are single-cycle strobes, no ready path.
// Ports: userinput/load/password_change/logout driven by master,
//        access_control_fb/deny/pw_changed/locked/tries_left driven by slave.
interface access_control_if #(
    parameter int PW_WIDTH = 16
);
    logic [PW_WIDTH-1:0] userinput;
    logic                load;
    logic                password_change;
    logic                logout;
    logic                access_control_fb;
    logic                deny;
    logic                pw_changed;
    logic                locked;
    logic [2:0]          tries_left;

    modport master (
        output userinput, load, password_change, logout,
        input  access_control_fb, deny, pw_changed, locked, tries_left
    );

    modport slave (
        input  userinput, load, password_change, logout,
        output access_control_fb, deny, pw_changed, locked, tries_left
    );
endinterface

// File: rtl/access_control_lockout_timer.sv
// Lockout down-counter: load sets LOCKOUT_CYCLES-1, en counts down to zero.
// Latency: done reflects the registered count (combinational from the register).
// Backpressure: none; the count simply holds at zero.
// Ports: clk, rst (async active-low), load, en in; done out.
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);
    import access_pkg::*;

    localparam int CW = lockout_cnt_width(LOCKOUT_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LOCKOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/access_control.sv
// Password check with fail counting and timed lockout; holds the stored password.
// Latency: load to access_control_fb high is 2 cycles; deny/pw_changed pulse 1 cycle after cause.
// Backpressure: none; loads arriving outside IDLE/GRANTED are dropped.
// Ports: clk, rst (async active-low), bus (access_control_if.slave).
// Option: define ACCESS_MASTER_KEY_EN to enable the MASTER_KEY override.
module access_control #(
    parameter int                  PW_WIDTH       = 16,
    parameter logic [PW_WIDTH-1:0] DEFAULT_PW     = access_pkg::DEFAULT_PW,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  LOCKOUT_CYCLES = 50_000_000,
    parameter logic [PW_WIDTH-1:0] MASTER_KEY     = access_pkg::MASTER_KEY
) (
    input  logic               clk,
    input  logic               rst,
    access_control_if.slave    bus
);
    import access_pkg::*;

    state_t              state, state_nxt;
    logic [PW_WIDTH-1:0] stored_pw;
    logic [PW_WIDTH-1:0] cand;
    logic [2:0]          fail_cnt, fail_nxt;
    logic [2:0]          fail_inc;
    logic                deny_q, deny_nxt;
    logic                pwc_q, pwc_nxt;
    logic                cand_ld, pw_wr, timer_ld, timer_done;
    logic                cand_ok, key_hit, chg_ok;

`ifdef ACCESS_MASTER_KEY_EN
    assign cand_ok = (cand == stored_pw) || (cand == MASTER_KEY);
    assign key_hit = bus.load && (bus.userinput == MASTER_KEY);
    // The override key must never become the stored password.
    assign chg_ok  = (bus.userinput != MASTER_KEY);
`else
    localparam logic [PW_WIDTH-1:0] unused_master_key = MASTER_KEY;
    assign cand_ok = (cand == stored_pw);
    assign key_hit = 1'b0;
    assign chg_ok  = 1'b1;
`endif

    assign fail_inc = fail_cnt + 3'd1;

    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        cand_ld   = 1'b0;
        pw_wr     = 1'b0;
        deny_nxt  = 1'b0;
        pwc_nxt   = 1'b0;
        timer_ld  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.load) begin
                    cand_ld   = 1'b1;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (cand_ok) begin
                    state_nxt = GRANTED;
                    fail_nxt  = '0;
                end else begin
                    deny_nxt = 1'b1;
                    fail_nxt = fail_inc;
                    if (fail_inc == 3'(MAX_TRIES)) begin
                        state_nxt = LOCKED;
                        timer_ld  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GRANTED: begin
                // logout has priority over a simultaneous password write
                if (bus.logout) begin
                    state_nxt = IDLE;
                end else if (bus.load && bus.password_change && chg_ok) begin
                    pw_wr   = 1'b1;
                    pwc_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (key_hit) begin
                    state_nxt = GRANTED;
                    fail_nxt  = '0;
                end else if (timer_done) begin
                    state_nxt = IDLE;
                    fail_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stored_pw <= DEFAULT_PW;
            cand      <= '0;
            fail_cnt  <= '0;
            deny_q    <= 1'b0;
            pwc_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
            deny_q   <= deny_nxt;
            pwc_q    <= pwc_nxt;
            if (cand_ld) cand <= bus.userinput;
            if (pw_wr)   stored_pw <= bus.userinput;
        end
    end

    lockout_timer #(
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_ld),
        .en   (state == LOCKED),
        .done (timer_done)
    );

    assign bus.access_control_fb = (state == GRANTED);
    assign bus.locked            = (state == LOCKED);
    assign bus.deny              = deny_q;
    assign bus.pw_changed        = pwc_q;
    assign bus.tries_left        = 3'(MAX_TRIES) - fail_cnt;

endmodule

// File: doc/access_control.md
Name: access_control

Overview:
Password-check stage directly downstream of the process controller. It consumes the controller's 16-bit `userinput`, `load` strobe and `password_change` flag, and holds the stored password. It validates login attempts, counts failures and enforces a timed lockout. It returns the `access_control_fb` level to the controller, plus status outputs for the LCD/LED path.

Parameters:
PW_WIDTH, 16, width of userinput and of the stored password
DEFAULT_PW, 16'h1234, password value loaded at reset
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (1..7)
LOCKOUT_CYCLES, 50_000_000, lockout duration in clk cycles (1 s at 50 MHz); must be >= 1
MASTER_KEY, 16'hBEEF, override key; used only when ACCESS_MASTER_KEY_EN is defined

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
userinput  in  PW_WIDTH  candidate password, or new password during a change
load  in  1  single-cycle strobe: userinput is valid this cycle
password_change  in  1  level; qualifies load as a password write when logged in
logout  in  1  single-cycle strobe: end the session
access_control_fb  out  1  level; high while logged in
deny  out  1  one-cycle pulse on each failed attempt
pw_changed  out  1  one-cycle pulse when a new password is committed
locked  out  1  level; high during lockout
tries_left  out  3  MAX_TRIES minus consecutive failures

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; stored_pw = DEFAULT_PW; fail count = 0; lockout counter = 0.
  - Outputs: access_control_fb=0, deny=0, pw_changed=0, locked=0, tries_left=MAX_TRIES.
- All state updates are on the clk rising edge. Pulses are registered and last exactly one cycle.
- States: IDLE, CHECK, GRANTED, LOCKED.
- IDLE:
  - load=1 -> capture userinput into cand; go to CHECK.
  - password_change is ignored in IDLE.
  - logout is ignored in IDLE.
- CHECK (exactly 1 cycle):
  - cand == stored_pw -> GRANTED; fail count cleared.
  - Mismatch -> deny pulses on the following cycle; fail count increments.
    - New count == MAX_TRIES -> LOCKED, and the lockout counter is loaded with LOCKOUT_CYCLES-1.
    - Otherwise -> IDLE.
  - Latency: load edge to access_control_fb high = 2 cycles.
- GRANTED (access_control_fb = 1):
  - logout=1 -> IDLE; access_control_fb falls the next cycle.
  - load=1 with password_change=1 -> stored_pw <= userinput; pw_changed pulses next cycle; stay in GRANTED.
  - load=1 with password_change=0 -> ignored.
  - logout and load in the same cycle -> logout wins; no password write.
- LOCKED (locked = 1):
  - Counter decrements once per cycle. All load strobes are ignored and no deny pulses are produced.
  - Counter == 0 -> IDLE; fail count cleared; tries_left = MAX_TRIES.
  - Total lockout duration = LOCKOUT_CYCLES cycles.
- tries_left = MAX_TRIES - fail count, updated the same cycle the count changes. It never underflows.
- Reset asserted mid-operation (including mid-lockout or mid-change):
  - Immediate return to reset values.
  - stored_pw reverts to DEFAULT_PW; password changes are not persistent.
- cand is not cleared after a check; it has no observable output.

Optional Feature:
ACCESS_MASTER_KEY_EN:
- Defined:
  - In IDLE, load with userinput == MASTER_KEY -> GRANTED via CHECK as normal.
  - In LOCKED, load with userinput == MASTER_KEY aborts lockout: next cycle GRANTED, locked=0, fail count cleared.
  - MASTER_KEY is never a valid new password: a change request with userinput == MASTER_KEY is ignored and produces no pw_changed pulse.
- Undefined: MASTER_KEY is unused and LOCKED ignores all loads.

Decomposition:
- Package access_pkg:
  - state enum (IDLE, CHECK, GRANTED, LOCKED);
  - DEFAULT_PW and MASTER_KEY constants;
  - function for the lockout counter width, clog2(LOCKOUT_CYCLES).
- One sub-module: lockout_timer.
  - Down-counter with load, count value and done output.
  - Parameterised by LOCKOUT_CYCLES.
  - Shares clk and rst (asynchronous, active-low).
- FSM, password register and fail counter stay in access_control.

Test Plan (LOCKOUT_CYCLES=8, MAX_TRIES=3):
1. Reset, then load with 16'h1234 -> access_control_fb=1 two cycles after load; tries_left=3; deny never asserted.
2. Three loads with 16'h0000 -> deny pulses 3 times; tries_left goes 2,1,0; locked=1 for exactly 8 cycles; a load of 16'h1234 during lockout is ignored; afterwards IDLE with tries_left=3.
3. Login, then load 16'hA5A5 with password_change=1 -> pw_changed pulse. Logout, load 16'h1234 -> deny. Load 16'hA5A5 -> granted.
4. In GRANTED, logout and load with password_change=1 and 16'h5555 in the same cycle -> access_control_fb=0 and no pw_changed. Next login with 16'h1234 succeeds.
5. Two failures, then a correct load -> granted and tries_left=3. Drop rst mid-lockout -> locked=0 immediately; stored_pw back to 16'h1234.
6. With ACCESS_MASTER_KEY_EN defined: lock out, then load 16'hBEEF -> locked=0 and access_control_fb=1 next cycle. A change request to 16'hBEEF produces no pw_changed.
